// File: rtl/cmd_uart_wrapper.sv
// cmd_uart_wrapper: full-duplex 8N1 UART that assembles two received bytes
// into a 16-bit command {high, low} and transmits single response bytes.
// Optional feature macro: CMD_TIMEOUT_EN. When it is defined, a high byte is
// dropped if the low byte does not start within TIMEOUT_CLKS idle clocks.
// dbg_state_o exposes the wrapper FSM state (0 = WAIT_HIGH, 1 = WAIT_LOW).
// Handshake: cmd_rdy rises when a full command is latched and stays high
// until clr_cmd_rdy is seen on a clock edge; a coinciding new command wins.
module cmd_uart_wrapper #(
  parameter int BAUD_DIV     = 5208,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done,
  output logic        dbg_state_o
);

  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);

  typedef enum logic { RX_IDLE, RX_BUSY } rx_state_t;
  typedef enum logic { TX_IDLE, TX_BUSY } tx_state_t;
  typedef enum logic { WAIT_HIGH, WAIT_LOW } wr_state_t;

  // ---------------- receiver ----------------
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t     rx_state_q, rx_state_d;
  logic [BW-1:0] rx_baud_q, rx_baud_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_rdy_q, rx_rdy_d;

  // Two-flop synchronizer plus one delay flop for edge detection, idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver state, counters and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_rdy_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_rdy_q   <= rx_rdy_d;
    end
  end

  // Sample 0 is the start bit (mid-bit), 1..8 data LSB first, 9 the stop bit.
  // rx_rdy_q pulses for one cycle after a good stop bit; rx_shift_q holds the byte.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_rdy_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_BUSY;
          rx_baud_d  = HALF_LAST;
          rx_bit_d   = '0;
        end
      end
      RX_BUSY: begin
        if (rx_baud_q != '0) begin
          rx_baud_d = rx_baud_q - 1'b1;
        end else begin
          rx_baud_d = BAUD_LAST;
          rx_bit_d  = rx_bit_q + 1'b1;
          if (rx_bit_q == 4'd0) begin
            if (rx_sync_q) rx_state_d = RX_IDLE;  // false start
          end else if (rx_bit_q == 4'd9) begin
            rx_state_d = RX_IDLE;
            rx_rdy_d   = rx_sync_q;                // framing error drops the byte
          end else begin
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- command assembly ----------------
  wr_state_t  state_q, state_d;
  logic [7:0] high_q, high_d;
  logic [15:0] cmd_q, cmd_d;
  logic       cmd_rdy_q, cmd_rdy_d;
  logic       timeout;

`ifdef CMD_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CLKS - 1);
  logic [TOW-1:0] to_cnt_q;

  // Counts idle receiver clocks while a high byte waits for its partner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else if (state_q == WAIT_LOW && rx_state_q == RX_IDLE && !timeout)
      to_cnt_q <= to_cnt_q + 1'b1;
    else to_cnt_q <= '0;
  end

  assign timeout = (state_q == WAIT_LOW) && (to_cnt_q == TO_LAST);
`else
  localparam int unused_timeout_clks = TIMEOUT_CLKS;
  assign timeout = 1'b0;
`endif

  // Wrapper FSM and command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_HIGH;
      high_q    <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      high_q    <= high_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  // A completed low byte sets cmd_rdy even if clr_cmd_rdy is high that cycle.
  always_comb begin
    state_d   = state_q;
    high_d    = high_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q & ~clr_cmd_rdy;
    if (rx_rdy_q) begin
      if (state_q == WAIT_HIGH) begin
        high_d    = rx_shift_q;
        state_d   = WAIT_LOW;
        cmd_rdy_d = 1'b0;
      end else begin
        cmd_d     = {high_q, rx_shift_q};
        state_d   = WAIT_HIGH;
        cmd_rdy_d = 1'b1;
      end
    end else if (timeout) begin
      state_d = WAIT_HIGH;
      high_d  = '0;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t     tx_state_q, tx_state_d;
  logic [BW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic          tx_done_q, tx_done_d;

  // Transmitter registers; the shifter idles at all ones so TX idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // Frame {stop, data, start} shifts out LSB first, one bit per BAUD_DIV clocks.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = tx_done_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (trmt) begin
          tx_state_d = TX_BUSY;
          tx_shift_d = {1'b1, resp, 1'b0};
          tx_baud_d  = BAUD_LAST;
          tx_bit_d   = '0;
          tx_done_d  = 1'b0;
        end
      end
      TX_BUSY: begin
        if (tx_baud_q != '0) begin
          tx_baud_d = tx_baud_q - 1'b1;
        end else begin
          tx_baud_d  = BAUD_LAST;
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          if (tx_bit_q == 4'd9) begin
            tx_state_d = TX_IDLE;
            tx_done_d  = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign TX          = tx_shift_q[0];
  assign tx_done     = tx_done_q;
  assign cmd         = cmd_q;
  assign cmd_rdy     = cmd_rdy_q;
  assign dbg_state_o = (state_q == WAIT_LOW);

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Directed testbench for cmd_uart_wrapper with BAUD_DIV=16, TIMEOUT_CLKS=400.
module tb_cmd_uart_wrapper;

  logic        clk;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;
  logic        dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  cmd_uart_wrapper #(.BAUD_DIV(16), .TIMEOUT_CLKS(400)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt), .tx_done(tx_done),
    .dbg_state_o(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one 8N1 frame starting at a negedge; stop bit lasts 'tail' clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int tail);
    logic [8:0] f;
    f = {b, 1'b0};
    for (int i = 0; i < 9; i++) begin
      RX = f[i];
      repeat (16) @(negedge clk);
    end
    RX = stop_v;
    repeat (tail) @(negedge clk);
    RX = 1'b1;
  endtask

  // Checks a TX frame; called at the first negedge after trmt was accepted.
  task automatic check_tx_frame(input logic [7:0] b, input logic poke);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    tests_run++;
    if (tx_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL tx_done_clear: got %b expected 0", tx_done);
    end
    for (int i = 0; i < 10; i++) begin
      repeat (8) @(negedge clk);
      tests_run++;
      if (TX !== f[i]) begin
        tests_failed++;
        $display("FAIL tx_bit%0d (byte %h): got %b expected %b", i, b, TX, f[i]);
      end
      if (poke && i == 4) begin
        resp = 8'hFF;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        repeat (7) @(negedge clk);
      end else if (i == 9) begin
        repeat (7) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
    end
    tests_run++;
    if (tx_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL tx_done_early: got %b expected 0", tx_done);
    end
    @(negedge clk);
    tests_run++;
    if (tx_done !== 1'b1 || TX !== 1'b1) begin
      tests_failed++;
      $display("FAIL tx_done_set: got done=%b TX=%b expected done=1 TX=1", tx_done, TX);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; resp = 8'h00; trmt = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (TX !== 1'b1 || cmd !== 16'h0000 || cmd_rdy !== 1'b0 || tx_done !== 1'b0 || dbg_state !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got TX=%b cmd=%h rdy=%b done=%b st=%b expected 1 0000 0 0 0",
               TX, cmd, cmd_rdy, tx_done, dbg_state);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    send_frame(8'h2D, 1'b1, 16);
    repeat (20) @(negedge clk);
    tests_run++;
    if (dbg_state !== 1'b1 || cmd_rdy !== 1'b0 || cmd !== 16'h0000) begin
      tests_failed++;
      $display("FAIL basic_high: got st=%b rdy=%b cmd=%h expected 1 0 0000", dbg_state, cmd_rdy, cmd);
    end
    send_frame(8'h37, 1'b1, 11);
    tests_run++;
    if (cmd_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_rdy_early: got %b expected 0", cmd_rdy);
    end
    @(negedge clk);
    tests_run++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h2D37 || dbg_state !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_cmd: got rdy=%b cmd=%h st=%b expected 1 2d37 0", cmd_rdy, cmd, dbg_state);
    end
    repeat (10) @(negedge clk);
    tests_run++;
    if (cmd_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_rdy_hold: got %b expected 1", cmd_rdy);
    end
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    tests_run++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'h2D37) begin
      tests_failed++;
      $display("FAIL basic_clr: got rdy=%b cmd=%h expected 0 2d37", cmd_rdy, cmd);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_tx();
    resp = 8'hC3;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    check_tx_frame(8'hC3, 1'b1);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_frame_error();
    // short low glitch: start bit re-sampled high, must not start a byte
    RX = 1'b0;
    repeat (3) @(negedge clk);
    RX = 1'b1;
    repeat (200) @(negedge clk);
    tests_run++;
    if (dbg_state !== 1'b0) begin
      tests_failed++;
      $display("FAIL false_start: got st=%b expected 0", dbg_state);
    end
    send_frame(8'hA5, 1'b1, 16);
    repeat (20) @(negedge clk);
    send_frame(8'h5A, 1'b0, 16);
    repeat (20) @(negedge clk);
    tests_run++;
    if (cmd_rdy !== 1'b0 || dbg_state !== 1'b1 || cmd !== 16'h2D37) begin
      tests_failed++;
      $display("FAIL framing_err: got rdy=%b st=%b cmd=%h expected 0 1 2d37", cmd_rdy, dbg_state, cmd);
    end
    send_frame(8'h5A, 1'b1, 16);
    repeat (20) @(negedge clk);
    tests_run++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'hA55A || dbg_state !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_recover: got rdy=%b cmd=%h st=%b expected 1 a55a 0", cmd_rdy, cmd, dbg_state);
    end
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_collision();
    send_frame(8'h3C, 1'b1, 16);
    repeat (20) @(negedge clk);
    send_frame(8'hE1, 1'b1, 11);
    clr_cmd_rdy = 1'b1;
    resp = 8'h5E;
    trmt = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    trmt = 1'b0;
    tests_run++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h3CE1) begin
      tests_failed++;
      $display("FAIL set_wins: got rdy=%b cmd=%h expected 1 3ce1", cmd_rdy, cmd);
    end
    check_tx_frame(8'h5E, 1'b0);
    tests_run++;
    if (cmd_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL set_wins_hold: got %b expected 1", cmd_rdy);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [15:0] exp_cmd;
    logic        exp_rdy;
    logic        exp_st_idle;
    logic        exp_st_end;
`ifdef CMD_TIMEOUT_EN
    exp_cmd = 16'hABCD; exp_rdy = 1'b1; exp_st_idle = 1'b0; exp_st_end = 1'b0;
`else
    exp_cmd = 16'h99AB; exp_rdy = 1'b0; exp_st_idle = 1'b1; exp_st_end = 1'b1;
`endif
    send_frame(8'h99, 1'b1, 16);
    tests_run++;
    if (cmd_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL high_clears_rdy: got %b expected 0", cmd_rdy);
    end
    repeat (500) @(negedge clk);
    tests_run++;
    if (dbg_state !== exp_st_idle || cmd !== 16'h3CE1) begin
      tests_failed++;
      $display("FAIL timeout_idle: got st=%b cmd=%h expected %b 3ce1", dbg_state, cmd, exp_st_idle);
    end
    send_frame(8'hAB, 1'b1, 16);
    repeat (20) @(negedge clk);
    send_frame(8'hCD, 1'b1, 16);
    repeat (20) @(negedge clk);
    tests_run++;
    if (cmd !== exp_cmd || cmd_rdy !== exp_rdy || dbg_state !== exp_st_end) begin
      tests_failed++;
      $display("FAIL timeout_cmd: got cmd=%h rdy=%b st=%b expected %h %b %b",
               cmd, cmd_rdy, dbg_state, exp_cmd, exp_rdy, exp_st_end);
    end
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    // return to WAIT_HIGH in either build with a throwaway pair if needed
    if (dbg_state === 1'b1) begin
      send_frame(8'h00, 1'b1, 16);
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [8:0] f;
    send_frame(8'hEE, 1'b1, 16);
    repeat (20) @(negedge clk);
    f = {8'h77, 1'b0};
    for (int i = 0; i < 5; i++) begin
      RX = f[i];
      repeat (16) @(negedge clk);
    end
    RX = f[5];
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    RX = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'h0000 || dbg_state !== 1'b0 || TX !== 1'b1 || tx_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: got rdy=%b cmd=%h st=%b TX=%b done=%b expected 0 0000 0 1 0",
               cmd_rdy, cmd, dbg_state, TX, tx_done);
    end
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    tests_run++;
    if (cmd_rdy !== 1'b0 || dbg_state !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_after: got rdy=%b st=%b expected 0 0", cmd_rdy, dbg_state);
    end
    send_frame(8'h12, 1'b1, 16);
    repeat (20) @(negedge clk);
    send_frame(8'h34, 1'b1, 16);
    repeat (20) @(negedge clk);
    tests_run++;
    if (cmd !== 16'h1234 || cmd_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_cmd: got cmd=%h rdy=%b expected 1234 1", cmd, cmd_rdy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tx();
    test_frame_error();
    test_collision();
    test_timeout();
    test_reset_mid_byte();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cmd_uart_wrapper.md
CMD_UART_WRAPPER -- requirements
Module: cmd_uart_wrapper

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 5208, clocks per bit (50 MHz / 9600 baud).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 1000000, clocks allowed between high and low command bytes.
REQ-003 SHALL have port clk  input  1  system clock; all flops on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port RX  input  1  serial in from remote, 8N1, LSB first, idle high.
REQ-006 SHALL have port TX  output  1  serial out to remote, 8N1, LSB first, idle high.
REQ-007 SHALL have port cmd  output  16  assembled command {high byte, low byte}.
REQ-008 SHALL have port cmd_rdy  output  1  cmd valid, held until cleared.
REQ-009 SHALL have port clr_cmd_rdy  input  1  consumer acknowledge, clears cmd_rdy.
REQ-010 SHALL have port resp  input  8  response byte to transmit.
REQ-011 SHALL have port trmt  input  1  one-cycle pulse, start transmitting resp.
REQ-012 SHALL have port tx_done  output  1  set when response stop bit is completely sent.

Function
REQ-013 RX SHALL pass through two flops, both preset to 1 on reset, before any use.
REQ-014 Receiver SHALL detect start on a synchronized high-to-low transition while idle.
REQ-015 Receiver SHALL sample the start bit at BAUD_DIV/2 clocks, then each following bit every BAUD_DIV clocks, for 10 samples total.
REQ-016 Start bit sampled high SHALL abort reception and return the receiver to idle, with no byte delivered.
REQ-017 Stop bit sampled low (framing error) SHALL discard the byte, leaving the wrapper FSM unchanged.
REQ-018 Wrapper FSM SHALL have states WAIT_HIGH (reset) and WAIT_LOW.
REQ-019 In WAIT_HIGH, a valid byte SHALL be latched as the high byte and the FSM SHALL move to WAIT_LOW.
REQ-020 When a valid high byte is received, cmd_rdy SHALL clear in that same cycle.
REQ-021 In WAIT_LOW, a valid byte SHALL update cmd to {high, low} and move the FSM to WAIT_HIGH.
REQ-022 cmd_rdy SHALL assert on the clock edge following the stop-bit sample of the low byte.
REQ-023 cmd SHALL stay stable while cmd_rdy is high, until the next high byte completes.
REQ-024 clr_cmd_rdy SHALL clear cmd_rdy on the next edge.
REQ-025 If clr_cmd_rdy coincides with a low-byte completion, set SHALL win and cmd_rdy SHALL stay 1.
REQ-026 Transmitter SHALL load resp on trmt while idle and drive start, resp[0..7], then stop, each bit for BAUD_DIV clocks.
REQ-027 trmt while the transmitter is busy SHALL be ignored, with the shifted byte unchanged.
REQ-028 tx_done SHALL set when the stop-bit period ends and SHALL clear when trmt is accepted.
REQ-029 Receiver and transmitter SHALL operate fully concurrently (full duplex).

Reset
REQ-030 On rst_n low, outputs SHALL be: TX=1, cmd=0x0000, cmd_rdy=0, tx_done=0.
REQ-031 On rst_n low, the FSM SHALL go to WAIT_HIGH and both baud counters and bit counters SHALL clear.
REQ-032 Reset asserted mid-byte SHALL abandon the partial byte, with no byte delivered after release.

Configuration
REQ-033 With macro CMD_TIMEOUT_EN defined, a counter SHALL run while in WAIT_LOW and receiver idle.
REQ-034 With CMD_TIMEOUT_EN defined, reaching TIMEOUT_CLKS SHALL discard the high byte and return to WAIT_HIGH.
REQ-035 With CMD_TIMEOUT_EN defined, cmd and cmd_rdy SHALL be unaffected by a timeout.
REQ-036 Without CMD_TIMEOUT_EN, no timeout counter SHALL exist and WAIT_LOW SHALL wait indefinitely.

Verification (bench uses BAUD_DIV=16, TIMEOUT_CLKS=400)
REQ-037 Send bytes 0x2D then 0x37 -> cmd=0x2D37; cmd_rdy=1 one clock after low stop-bit sample; clr_cmd_rdy pulse -> cmd_rdy=0 next edge.
REQ-038 Send 0xA5, then 0x5A with stop bit forced 0, then 0x5A valid -> exactly one cmd_rdy; cmd=0xA55A.
REQ-039 Pulse trmt with resp=0xC3 -> TX low 16 clocks, then bits 1,1,0,0,0,0,1,1 at 16 clocks each, then high; tx_done=1 after 160 clocks; second trmt mid-frame changes nothing.
REQ-040 Assert rst_n low during bit 4 of the low byte -> cmd_rdy=0, cmd=0x0000, FSM in WAIT_HIGH; next pair 0x12,0x34 -> cmd=0x1234.
REQ-041 (CMD_TIMEOUT_EN) Send 0x99, idle 500 clocks, then 0xAB, 0xCD -> cmd=0xABCD; without the macro the same stimulus -> cmd=0x99AB.
REQ-042 Hold clr_cmd_rdy high during a low-byte completion, with simultaneous trmt -> cmd_rdy=1 and correct TX frame.
